// File: rtl/agc_stim_pkg.sv
// agc_stim_pkg
//   Shared types for the AGC stimulus sequencer: channel mode encoding,
//   configuration field selects and the per-channel state encoding.
package agc_stim_pkg;

  typedef enum logic [1:0] {
    STIM_OFF      = 2'd0,
    STIM_ONESHOT  = 2'd1,
    STIM_PERIODIC = 2'd2,
    STIM_LEVEL    = 2'd3
  } stim_mode_e;

  localparam logic [1:0] CFG_DELAY  = 2'd0;
  localparam logic [1:0] CFG_WIDTH  = 2'd1;
  localparam logic [1:0] CFG_PERIOD = 2'd2;
  localparam logic [1:0] CFG_MODE   = 2'd3;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_ACTIVE = 2'd2,
    CH_GAP    = 2'd3
  } ch_state_e;

endpackage

// File: rtl/agc_stim_channel.sv
// agc_stim_channel
//   One stimulus channel: config registers (delay, width, period, mode),
//   a four-state FSM and one down-counter, all timed in AGC CLOCK ticks.
// Ports:
//   clk, rst       SIM_CLK and synchronous active-high reset
//   tick           one-cycle CLOCK rising-edge pulse from the prescaler
//   arm, abort     start / stop strobes (abort has priority)
//   cfg_we         field write, already qualified by the top (channel idle)
//   cfg_field      0 delay, 1 width, 2 period, 3 mode
//   cfg_data       write data (mode uses bits [1:0])
//   ch_out         registered stimulus output, IDLE_LEVEL when not ACTIVE
//   busy           channel not IDLE
//   done           one-cycle pulse when a one-shot completes
//   arm_rej        arm seen while busy (combinational, registered by the top)
module agc_stim_channel
  import agc_stim_pkg::*;
#(
  parameter int   CNT_W      = 24,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             arm,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_field,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             ch_out,
  output logic             busy,
  output logic             done,
  output logic             arm_rej
);

  ch_state_e        state;
  stim_mode_e       mode_r;
  logic [CNT_W-1:0] delay_r;
  logic [CNT_W-1:0] width_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] cnt;

  // A zero width still produces a one-tick pulse.
  function automatic logic [CNT_W-1:0] width_reload(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  // Gap lasts period-width ticks, but never less than one so the train toggles.
  function automatic logic [CNT_W-1:0] gap_reload(input logic [CNT_W-1:0] p,
                                                  input logic [CNT_W-1:0] w);
    return (p > w) ? p - w - CNT_W'(1) : '0;
  endfunction

  assign busy    = (state != CH_IDLE);
  assign arm_rej = arm && !abort && (state != CH_IDLE);

  // ch_out is assigned alongside each state change so it tracks the
  // registered state without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CH_IDLE;
      mode_r   <= STIM_OFF;
      delay_r  <= '0;
      width_r  <= '0;
      period_r <= '0;
      ch_out   <= IDLE_LEVEL;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_we) begin
        case (cfg_field)
          CFG_DELAY:  delay_r  <= cfg_data;
          CFG_WIDTH:  width_r  <= cfg_data;
          CFG_PERIOD: period_r <= cfg_data;
          default:    mode_r   <= stim_mode_e'(cfg_data[1:0]);
        endcase
      end
      if (abort) begin
        state  <= CH_IDLE;
        ch_out <= IDLE_LEVEL;
      end else begin
        case (state)
          CH_IDLE: begin
            if (arm && mode_r != STIM_OFF) begin
              state <= CH_DELAY;
              cnt   <= delay_r;
            end
          end
          CH_DELAY, CH_GAP: begin
            if (tick) begin
              if (cnt == '0) begin
                state  <= CH_ACTIVE;
                cnt    <= width_reload(width_r);
                ch_out <= ~IDLE_LEVEL;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          default: begin
            if (tick) begin
              if (cnt == '0) begin
                case (mode_r)
                  STIM_ONESHOT: begin
                    state  <= CH_IDLE;
                    ch_out <= IDLE_LEVEL;
                    done   <= 1'b1;
                  end
                  STIM_PERIODIC: begin
                    state  <= CH_GAP;
                    cnt    <= gap_reload(period_r, width_r);
                    ch_out <= IDLE_LEVEL;
                  end
                  default: ;  // LEVEL holds until abort or reset
                endcase
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/agc_stim_sequencer.sv
// agc_stim_sequencer
//   Generates the AGC master CLOCK from SIM_CLK and drives NUM_CH
//   programmable stimulus channels (one-shot, periodic or level).
// Ports:
//   SIM_CLK, SIM_RST  sole clock, synchronous active-high reset
//   cfg_we/ch/field/data  config write port (dropped if channel busy or
//                         cfg_ch out of range)
//   arm, abort        per-channel start / stop strobes
//   CLOCK             generated clock, period 2*CLK_HALF SIM_CLK cycles
//   clk_tick          one-cycle pulse coincident with each CLOCK 0->1
//   ch_out, busy, done  per-channel stimulus, not-idle, one-shot completion
//   err               one-cycle pulse on a rejected arm or config write
module agc_stim_sequencer
  import agc_stim_pkg::*;
#(
  parameter int                NUM_CH     = 8,
  parameter int                CNT_W      = 24,
  parameter int                CLK_HALF   = 12,
  parameter logic [NUM_CH-1:0] IDLE_LEVEL = {NUM_CH{1'b0}}
) (
  input  logic                                          SIM_CLK,
  input  logic                                          SIM_RST,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                    cfg_field,
  input  logic [CNT_W-1:0]                              cfg_data,
  input  logic [NUM_CH-1:0]                             arm,
  input  logic [NUM_CH-1:0]                             abort,
  output logic                                          CLOCK,
  output logic                                          clk_tick,
  output logic [NUM_CH-1:0]                             ch_out,
  output logic [NUM_CH-1:0]                             busy,
  output logic [NUM_CH-1:0]                             done,
  output logic                                          err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic [PRE_W-1:0]  pre_cnt;
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] arm_rej;
  logic              cfg_ch_ok;
  logic              cfg_err;

  // When NUM_CH fills the select width every cfg_ch value is a real channel.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign cfg_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign cfg_ch_ok = ({1'b0, cfg_ch} < NUM_CH_V);
  end

  assign cfg_err = cfg_we && (!cfg_ch_ok || (|(cfg_hit & busy)));

  // Prescaler: CLOCK toggles at each wrap; clk_tick marks the rising wrap.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      pre_cnt  <= '0;
      CLOCK    <= 1'b0;
      clk_tick <= 1'b0;
      err      <= 1'b0;
    end else begin
      clk_tick <= 1'b0;
      if (pre_cnt == PRE_W'(CLK_HALF - 1)) begin
        pre_cnt  <= '0;
        CLOCK    <= ~CLOCK;
        clk_tick <= ~CLOCK;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      err <= cfg_err | (|arm_rej);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign cfg_hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    agc_stim_channel #(
      .CNT_W      (CNT_W),
      .IDLE_LEVEL (IDLE_LEVEL[gi])
    ) u_ch (
      .clk       (SIM_CLK),
      .rst       (SIM_RST),
      .tick      (clk_tick),
      .arm       (arm[gi]),
      .abort     (abort[gi]),
      .cfg_we    (cfg_hit[gi] && !busy[gi]),
      .cfg_field (cfg_field),
      .cfg_data  (cfg_data),
      .ch_out    (ch_out[gi]),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .arm_rej   (arm_rej[gi])
    );
  end

endmodule

// File: tb/tb_agc_stim_sequencer.sv
// Testbench for agc_stim_sequencer (NUM_CH=8, CLK_HALF=4, IDLE_LEVEL=8'h10),
// with a second NUM_CH=5 instance sharing the config bus so that an
// out-of-range cfg_ch can be driven.
module tb_agc_stim_sequencer;
  import agc_stim_pkg::*;

  localparam logic [7:0] IDLE = 8'h10;

  logic        SIM_CLK;
  logic        SIM_RST;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_field;
  logic [23:0] cfg_data;
  logic [7:0]  arm;
  logic [7:0]  abort;
  logic        CLOCK, clk_tick, err;
  logic [7:0]  ch_out, busy, done;
  logic        clock5, tick5, err5;
  logic [4:0]  out5, busy5, done5;

  agc_stim_sequencer #(.NUM_CH(8), .CNT_W(24), .CLK_HALF(4), .IDLE_LEVEL(IDLE)) u_dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .arm(arm), .abort(abort),
    .CLOCK(CLOCK), .clk_tick(clk_tick), .ch_out(ch_out), .busy(busy),
    .done(done), .err(err));

  agc_stim_sequencer #(.NUM_CH(5), .CNT_W(24), .CLK_HALF(4), .IDLE_LEVEL(5'h10)) u_dut5 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .arm(arm[4:0]), .abort(abort[4:0]),
    .CLOCK(clock5), .clk_tick(tick5), .ch_out(out5), .busy(busy5),
    .done(done5), .err(err5));

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  int errors = 0;
  int checks = 0;
  int ecount = 0;   // SIM_CLK edges since the last reset release
  int n;

  typedef struct {
    logic        we;
    logic [2:0]  ch;
    logic [1:0]  field;
    logic [23:0] data;
    logic [7:0]  arm;
    logic [7:0]  abort;
    logic        exp_err;
    logic        exp_err5;
    logic [7:0]  exp_busy;
  } vec_t;
  vec_t tbl[13];

  // Behavioural model state for the randomized phase.
  int m_delay[8], m_width[8], m_period[8], m_mode[8], m_t[8];
  bit m_act[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic step();
    @(posedge SIM_CLK);
    #1;
    ecount++;
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] f, input int d);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_field = f; cfg_data = 24'(d);
    step();
    cfg_we = 1'b0;
  endtask

  // Output of a channel in tick terms: active once delay+1 ticks have passed,
  // then width ticks high followed by a gap of period-width (min 1) ticks.
  function automatic bit m_high(input int i);
    int w, g, s;
    if (!m_act[i]) return 1'b0;
    w = (m_width[i] == 0) ? 1 : m_width[i];
    g = (m_period[i] > m_width[i]) ? m_period[i] - m_width[i] : 1;
    if (m_t[i] < m_delay[i] + 1) return 1'b0;
    s = m_t[i] - m_delay[i] - 1;
    case (m_mode[i])
      1: return s < w;
      2: return (s % (w + g)) < w;
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_oneshot(input bit inject);
    int a_e, r_e, f_e, e, k;
    logic exp_err;
    arm = 8'h01;
    step();
    arm = 8'h00;
    a_e = ecount;
    chk("os_armed", 64'({busy[0], ch_out[0], err}), 64'({1'b1, 1'b0, 1'b0}));
    e = a_e; k = 0; r_e = 0;
    while (k < 6) begin
      e++;
      if (e % 8 == 5) begin
        k++;
        if (k == 4) r_e = e;
      end
    end
    f_e = e;
    while (ecount < f_e + 2) begin
      if (inject && ecount == a_e + 2) arm = 8'h01;
      if (inject && ecount == a_e + 6) begin
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_field = CFG_WIDTH; cfg_data = 24'd7;
      end
      step();
      arm = 8'h00; cfg_we = 1'b0;
      exp_err = inject && (ecount == a_e + 3 || ecount == a_e + 7);
      chk(inject ? "os_inject" : "os_plain",
          64'({ch_out, busy[0], done[0], err}),
          64'({IDLE ^ {7'b0, (ecount >= r_e && ecount < f_e)}, (ecount < f_e),
               (ecount == f_e), exp_err}));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 3'd2, CFG_DELAY, 24'd5, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 3'd2, CFG_MODE,  24'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h04, 8'h04, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04};
    tbl[5]  = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h04, 8'h00, 1'b1, 1'b1, 8'h04};
    tbl[6]  = '{1'b1, 3'd2, CFG_WIDTH, 24'd3, 8'h00, 8'h00, 1'b1, 1'b1, 8'h04};
    tbl[7]  = '{1'b1, 3'd7, CFG_MODE,  24'd1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h04};
    tbl[8]  = '{1'b1, 3'd5, CFG_DELAY, 24'd1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h04};
    tbl[9]  = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h00, 8'h04, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 3'd2, CFG_WIDTH, 24'd2, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01};
    tbl[11] = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h01, 8'h04, 1'b1, 1'b1, 8'h01};
    tbl[12] = '{1'b0, 3'd0, CFG_DELAY, 24'd0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00};

    SIM_RST = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_field = 2'd0;
    cfg_data = 24'd0; arm = 8'h00; abort = 8'h00;
    step(); step();
    chk("reset_state", 64'({CLOCK, clk_tick, err, ch_out, busy, done}),
        64'({3'b000, IDLE, 8'h00, 8'h00}));
    SIM_RST = 1'b0;
    ecount = 0;

    // Prescaler: CLOCK low for 4 edges, then toggles every 4; tick every 8.
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("prescaler", 64'({CLOCK, clk_tick, ch_out, busy}),
          64'({((ecount / 4) % 2 == 1), (ecount % 8 == 4), IDLE, 8'h00}));
    end

    // One-shot on ch0, first with a busy arm and busy cfg write injected,
    // then again to confirm the rejected width write left width at 2.
    cfg_write(0, CFG_DELAY, 3);
    cfg_write(0, CFG_WIDTH, 2);
    cfg_write(0, CFG_MODE, 1);
    run_oneshot(1'b1);
    run_oneshot(1'b0);

    // Periodic ch1: width 1, period 4 gives 1,0,0,0 per tick; abort while high.
    cfg_write(1, CFG_WIDTH, 1);
    cfg_write(1, CFG_PERIOD, 4);
    cfg_write(1, CFG_MODE, 2);
    arm = 8'h02; step(); arm = 8'h00;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (ecount % 8 == 5) n++;
      chk("per_pattern", 64'({ch_out[1], busy[1], done[1]}),
          64'({(n >= 1 && ((n - 1) % 4 == 0)), 1'b1, 1'b0}));
      if (n == 5 && ecount % 8 == 0) break;
    end
    chk("per_reach", 64'(n), 64'(5));
    abort = 8'h02; step(); abort = 8'h00;
    chk("per_abort", 64'({ch_out[1], busy[1], done[1], err}), 64'(0));
    step();
    chk("per_abort_hold", 64'({ch_out[1], busy[1], done[1]}), 64'(0));

    // Active-low level on ch4: drops after the first tick, holds 100 ticks.
    cfg_write(4, CFG_MODE, 3);
    arm = 8'h10; step(); arm = 8'h00;
    chk("lvl_armed", 64'({ch_out[4], busy[4]}), 64'(2'b11));
    n = 0;
    while (n < 101) begin
      step();
      if (ecount % 8 == 5) n++;
      chk("lvl_hold", 64'({ch_out[4], busy[4], done[4]}), 64'({(n == 0), 1'b1, 1'b0}));
    end
    abort = 8'h10; step(); abort = 8'h00;
    chk("lvl_abort", 64'({ch_out[4], busy[4], done[4]}), 64'(3'b100));

    // Error and priority vectors.
    for (int r = 0; r < 13; r++) begin
      cfg_we = tbl[r].we; cfg_ch = tbl[r].ch; cfg_field = tbl[r].field;
      cfg_data = tbl[r].data; arm = tbl[r].arm; abort = tbl[r].abort;
      step();
      cfg_we = 1'b0; arm = 8'h00; abort = 8'h00;
      chk($sformatf("tbl%0d", r), 64'({err, err5, busy}),
          64'({tbl[r].exp_err, tbl[r].exp_err5, tbl[r].exp_busy}));
    end

    // Reset while ch0 is high and ch1 is in its gap.
    arm = 8'h03; step(); arm = 8'h00;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      step();
      if (ecount % 8 == 5) n++;
    end
    step(); step();
    chk("pre_rst", 64'({ch_out[1:0], busy[1:0]}), 64'(4'b0111));
    SIM_RST = 1'b1;
    step();
    chk("mid_rst", 64'({CLOCK, clk_tick, err, ch_out, busy, done}),
        64'({3'b000, IDLE, 8'h00, 8'h00}));
    step();
    SIM_RST = 1'b0;
    ecount = 0;
    arm = 8'h03; step(); arm = 8'h00;
    chk("cfg_cleared", 64'({busy, err, ch_out, done}), 64'({8'h00, 1'b0, IDLE, 8'h00}));

    // Randomized traffic against the tick-count model.
    for (int i = 0; i < 8; i++) begin
      m_delay[i] = 0; m_width[i] = 0; m_period[i] = 0; m_mode[i] = 0;
      m_t[i] = 0; m_act[i] = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] a, ab, pre_busy, exp_out, exp_busy, exp_done;
      logic       exp_err, tk, we;
      int         ch, f, d, w;
      we = ($urandom_range(3) == 0);
      ch = $urandom_range(7);
      f  = $urandom_range(3);
      d  = (f == 2) ? $urandom_range(7) : $urandom_range(3);
      a  = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      ab = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom) &
           8'($urandom) & 8'($urandom);
      if (we) a[ch] = 1'b0;
      cfg_we = we; cfg_ch = 3'(ch); cfg_field = 2'(f); cfg_data = 24'(d);
      arm = a; abort = ab;

      for (int i = 0; i < 8; i++) pre_busy[i] = m_act[i];
      exp_err = (we && pre_busy[ch]) || (|(a & ~ab & pre_busy));
      tk = ((ecount + 1) % 8 == 5);
      for (int i = 0; i < 8; i++) begin
        exp_done[i] = 1'b0;
        if (ab[i]) begin
          m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
          if (a[i] && m_mode[i] != 0) begin
            m_act[i] = 1'b1;
            m_t[i] = 0;
          end
        end else if (tk) begin
          m_t[i]++;
          w = (m_width[i] == 0) ? 1 : m_width[i];
          if (m_mode[i] == 1 && m_t[i] >= m_delay[i] + 1 + w) begin
            m_act[i] = 1'b0;
            exp_done[i] = 1'b1;
          end
        end
      end
      if (we && !pre_busy[ch]) begin
        case (f)
          0: m_delay[ch] = d;
          1: m_width[ch] = d;
          2: m_period[ch] = d;
          default: m_mode[ch] = d;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        exp_out[i]  = IDLE[i] ^ m_high(i);
        exp_busy[i] = m_act[i];
      end

      step();
      cfg_we = 1'b0; arm = 8'h00; abort = 8'h00;
      chk("random", 64'({CLOCK, clk_tick, err, ch_out, busy, done}),
          64'({((ecount / 4) % 2 == 1), (ecount % 8 == 4), exp_err,
               exp_out, exp_busy, exp_done}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
